// File: rtl/pe_cfg_pkg.sv
// Shared definitions for the PE configuration loader.
//   - FSM state encoding
//   - default header magic and header field offsets
//   - derivation of the configuration payload size
//   - packed layout of the configuration vector at default sizing
package pe_cfg_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StSkip,
        StCommit
    } cfg_state_e;

    localparam logic [7:0]  CFG_MAGIC_DEFAULT = 8'hC5;
    localparam logic [7:0]  BROADCAST_ID      = 8'hFF;
    localparam int unsigned WORD_WIDTH        = 32;

    // Header layout: {magic, dest id, word count, reserved}
    localparam int unsigned HDR_MAGIC_LSB = 24;
    localparam int unsigned HDR_ID_LSB    = 16;
    localparam int unsigned HDR_COUNT_LSB = 8;

    // Payload bits: instruction word, both crossbar select arrays and two enables.
    function automatic int unsigned calc_cfg_bits(input int unsigned inst_w,
                                                  input int unsigned n_out1,
                                                  input int unsigned cw1,
                                                  input int unsigned n_out2,
                                                  input int unsigned cw2);
        return inst_w + n_out1 * cw1 + n_out2 * cw2 + 2;
    endfunction

    function automatic int unsigned calc_num_words(input int unsigned cfg_bits);
        return (cfg_bits + WORD_WIDTH - 1) / WORD_WIDTH;
    endfunction

    // Configuration vector at default sizing (146 bits), LSB-first on the stream.
    typedef struct packed {
        logic        cb2_en;
        logic        cb1_en;
        logic [15:0] cb2;
        logic [63:0] cb1;
        logic [63:0] all;
    } cfg_t;

endpackage

// File: rtl/pe_config_loader_if.sv
// Configuration word stream (valid/ready).
//   cfg_data  : 32-bit stream word
//   cfg_valid : word valid (driven by the config network)
//   cfg_ready : loader can accept a word (driven by the loader)
interface pe_config_loader_if;
    logic [31:0] cfg_data;
    logic        cfg_valid;
    logic        cfg_ready;

    modport master (
        output cfg_data,
        output cfg_valid,
        input  cfg_ready
    );

    modport slave (
        input  cfg_data,
        input  cfg_valid,
        output cfg_ready
    );
endinterface

// File: rtl/pe_cfg_shadow_bank.sv
// Shadow store for an incoming configuration frame.
//   clk, rst_n : clock, asynchronous active-low reset (clears all words)
//   we_i       : write enable
//   idx_i      : word index to write
//   wdata_i    : word to write
//   rdata_o    : all words flattened, word 0 at the LSBs
module pe_cfg_shadow_bank #(
    parameter int unsigned NUM_WORDS = 5,
    parameter int unsigned IDX_W     = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we_i,
    input  logic [IDX_W-1:0]          idx_i,
    input  logic [31:0]               wdata_i,
    output logic [NUM_WORDS*32-1:0]   rdata_o
);

    logic [NUM_WORDS-1:0][31:0] mem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (we_i) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (idx_i == IDX_W'(i)) begin
                    mem_q[i] <= wdata_i;
                end
            end
        end
    end

    assign rdata_o = mem_q;

endmodule

// File: rtl/pe_config_loader.sv
// Per-PE configuration loader. Accepts header + payload frames from the config
// network, builds the config in a shadow bank and commits it atomically to the
// active registers that drive the PE crossbars and functional unit.
//   clk, rst_n   : clock, asynchronous active-low reset
//   cfg_if       : config word stream (slave side)
//   hold_i       : defer commit while the PE is mid-operation
//   flush_i      : synchronous abort of the frame in progress, clears err_o
//   config_all_o : active instruction word
//   config_cb1_o : active crossbar-1 selects, output 0 at the LSBs
//   config_cb2_o : active crossbar-2 selects
//   cb1_en_o     : active crossbar-1 enable
//   cb2_en_o     : active crossbar-2 enable
//   cfg_valid_o  : some config has been committed since reset
//   cfg_done_o   : one-cycle pulse in the first cycle a new config is visible
//   err_o        : sticky frame error
module pe_config_loader
    import pe_cfg_pkg::*;
#(
    parameter logic [7:0]  PE_ID           = 8'h00,
    parameter int unsigned INST_WIDTH      = 64,
    parameter int unsigned NUM_INPUTS_CB1  = 14,
    parameter int unsigned NUM_OUTPUTS_CB1 = 16,
    parameter int unsigned NUM_INPUTS_CB2  = 10,
    parameter int unsigned NUM_OUTPUTS_CB2 = 4,
    parameter logic [7:0]  CFG_MAGIC       = CFG_MAGIC_DEFAULT,
    localparam int unsigned CW1   = $clog2(NUM_INPUTS_CB1),
    localparam int unsigned CW2   = $clog2(NUM_INPUTS_CB2),
    localparam int unsigned CB1_W = NUM_OUTPUTS_CB1 * CW1,
    localparam int unsigned CB2_W = NUM_OUTPUTS_CB2 * CW2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pe_config_loader_if.slave      cfg_if,
    input  logic                   hold_i,
    input  logic                   flush_i,
    output logic [INST_WIDTH-1:0]  config_all_o,
    output logic [CB1_W-1:0]       config_cb1_o,
    output logic [CB2_W-1:0]       config_cb2_o,
    output logic                   cb1_en_o,
    output logic                   cb2_en_o,
    output logic                   cfg_valid_o,
    output logic                   cfg_done_o,
    output logic                   err_o
);

    localparam int unsigned CFG_BITS =
        calc_cfg_bits(INST_WIDTH, NUM_OUTPUTS_CB1, CW1, NUM_OUTPUTS_CB2, CW2);
    localparam int unsigned NUM_WORDS = calc_num_words(CFG_BITS);
    localparam int unsigned VEC_W     = NUM_WORDS * WORD_WIDTH;
    localparam int unsigned CNT_W     = $clog2(NUM_WORDS + 1);

    localparam logic [CNT_W-1:0] LAST_IDX      = CNT_W'(NUM_WORDS - 1);
    localparam logic [7:0]       NUM_WORDS_HDR = 8'(NUM_WORDS);

    localparam int unsigned CB1_LSB = INST_WIDTH;
    localparam int unsigned CB2_LSB = CB1_LSB + CB1_W;
    localparam int unsigned EN1_BIT = CB2_LSB + CB2_W;
    localparam int unsigned EN2_BIT = EN1_BIT + 1;

    cfg_state_e             state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [7:0]             skip_q;
    logic                   ready_q;

    logic [INST_WIDTH-1:0]  all_q;
    logic [CB1_W-1:0]       cb1_q;
    logic [CB2_W-1:0]       cb2_q;
    logic                   cb1_en_q;
    logic                   cb2_en_q;
    logic                   valid_q;
    logic                   done_q;
    logic                   err_q;

    logic                   accept;
    logic                   shadow_we;
    logic [VEC_W-1:0]       shadow_vec;
    logic [7:0]             hdr_magic;
    logic [7:0]             hdr_id;
    logic [7:0]             hdr_count;
    logic                   id_hit;

    always_comb begin
        accept    = cfg_if.cfg_valid && ready_q;
        // flush_i wins over a coincident transfer, so the word is dropped
        shadow_we = accept && (state_q == StLoad) && !flush_i;
        hdr_magic = cfg_if.cfg_data[HDR_MAGIC_LSB +: 8];
        hdr_id    = cfg_if.cfg_data[HDR_ID_LSB +: 8];
        hdr_count = cfg_if.cfg_data[HDR_COUNT_LSB +: 8];
        id_hit    = (hdr_id == PE_ID) || (hdr_id == BROADCAST_ID);
    end

    pe_cfg_shadow_bank #(
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (CNT_W)
    ) u_shadow (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (shadow_we),
        .idx_i   (cnt_q),
        .wdata_i (cfg_if.cfg_data),
        .rdata_o (shadow_vec)
    );

    // Top bits of the last payload word carry no configuration.
    if (VEC_W > CFG_BITS) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^shadow_vec[VEC_W-1:CFG_BITS];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            skip_q   <= '0;
            ready_q  <= 1'b0;
            all_q    <= '0;
            cb1_q    <= '0;
            cb2_q    <= '0;
            cb1_en_q <= 1'b0;
            cb2_en_q <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            // ready mirrors "next state is not COMMIT"; cleared below where that holds
            ready_q <= 1'b1;
            if (flush_i) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                skip_q  <= '0;
                err_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (accept) begin
                            if (hdr_magic != CFG_MAGIC) begin
                                err_q <= 1'b1;
                            end else if (hdr_count != NUM_WORDS_HDR) begin
                                err_q <= 1'b1;
                                if (hdr_count != 8'd0) begin
                                    state_q <= StSkip;
                                    skip_q  <= hdr_count;
                                end
                            end else if (id_hit) begin
                                state_q <= StLoad;
                                cnt_q   <= '0;
                            end else begin
                                state_q <= StSkip;
                                skip_q  <= NUM_WORDS_HDR;
                            end
                        end
                    end
                    StLoad: begin
                        if (accept) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                            if (cnt_q == LAST_IDX) begin
                                state_q <= StCommit;
                                ready_q <= 1'b0;
                            end
                        end
                    end
                    StSkip: begin
                        if (accept) begin
                            skip_q <= skip_q - 8'd1;
                            if (skip_q == 8'd1) begin
                                state_q <= StIdle;
                            end
                        end
                    end
                    StCommit: begin
                        if (hold_i) begin
                            ready_q <= 1'b0;
                        end else begin
                            all_q    <= shadow_vec[INST_WIDTH-1:0];
                            cb1_q    <= shadow_vec[CB1_LSB +: CB1_W];
                            cb2_q    <= shadow_vec[CB2_LSB +: CB2_W];
                            cb1_en_q <= shadow_vec[EN1_BIT];
                            cb2_en_q <= shadow_vec[EN2_BIT];
                            valid_q  <= 1'b1;
                            done_q   <= 1'b1;
                            state_q  <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign cfg_if.cfg_ready = ready_q;
    assign config_all_o     = all_q;
    assign config_cb1_o     = cb1_q;
    assign config_cb2_o     = cb2_q;
    assign cb1_en_o         = cb1_en_q;
    assign cb2_en_o         = cb2_en_q;
    assign cfg_valid_o      = valid_q;
    assign cfg_done_o       = done_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_pe_config_loader.sv
// Bench for pe_config_loader: frame-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pe_config_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hold_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [63:0] config_all_o;
    logic [63:0] config_cb1_o;
    logic [15:0] config_cb2_o;
    logic        cb1_en_o, cb2_en_o, cfg_valid_o, cfg_done_o, err_o;

    pe_config_loader_if cfg_if ();

    pe_config_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_if       (cfg_if),
        .hold_i       (hold_i),
        .flush_i      (flush_i),
        .config_all_o (config_all_o),
        .config_cb1_o (config_cb1_o),
        .config_cb2_o (config_cb2_o),
        .cb1_en_o     (cb1_en_o),
        .cb2_en_o     (cb2_en_o),
        .cfg_valid_o  (cfg_valid_o),
        .cfg_done_o   (cfg_done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;
    int max_stall = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    logic [63:0] m_all = '0, m_cb1 = '0;
    logic [15:0] m_cb2 = '0;
    logic        m_en1 = 0, m_en2 = 0, m_valid = 0, m_done = 0, m_err = 0, m_ready = 0;
    logic [31:0] m_pay[$];
    bit          m_collect = 0, m_pending = 0;
    int          m_skip = 0;

    task automatic model_reset();
        m_all = '0; m_cb1 = '0; m_cb2 = '0;
        m_en1 = 0; m_en2 = 0; m_valid = 0; m_done = 0; m_err = 0; m_ready = 0;
        m_pay.delete(); m_collect = 0; m_pending = 0; m_skip = 0;
    endtask

    task automatic model_step();
        logic        acc;
        logic [31:0] w;
        logic [159:0] vec;
        acc    = cfg_if.cfg_valid && m_ready;
        w      = cfg_if.cfg_data;
        m_done = 0;
        m_ready = 1;
        if (flush_i) begin
            m_collect = 0; m_pending = 0; m_skip = 0; m_err = 0; m_pay.delete();
        end else if (m_pending) begin
            if (hold_i) begin
                m_ready = 0;
            end else begin
                vec = '0;
                for (int k = 0; k < 5; k++) vec[32*k +: 32] = m_pay[k];
                m_all = vec[63:0];
                m_cb1 = vec[127:64];
                m_cb2 = vec[143:128];
                m_en1 = vec[144];
                m_en2 = vec[145];
                m_valid = 1; m_done = 1; m_pending = 0;
            end
        end else if (acc) begin
            if (m_collect) begin
                m_pay.push_back(w);
                if (m_pay.size() == 5) begin
                    m_collect = 0; m_pending = 1; m_ready = 0;
                end
            end else if (m_skip > 0) begin
                m_skip--;
            end else if (w[31:24] != 8'hC5) begin
                m_err = 1;
            end else if (w[15:8] != 8'd5) begin
                m_err = 1;
                m_skip = int'(w[15:8]);
            end else if (w[23:16] == 8'h00 || w[23:16] == 8'hFF) begin
                m_collect = 1;
                m_pay.delete();
            end else begin
                m_skip = 5;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_all", config_all_o, m_all);
            check("cmp_cb1", config_cb1_o, m_cb1);
            check("cmp_cb2", 64'(config_cb2_o), 64'(m_cb2));
            check("cmp_en1", 64'(cb1_en_o), 64'(m_en1));
            check("cmp_en2", 64'(cb2_en_o), 64'(m_en2));
            check("cmp_valid", 64'(cfg_valid_o), 64'(m_valid));
            check("cmp_done", 64'(cfg_done_o), 64'(m_done));
            check("cmp_err", 64'(err_o), 64'(m_err));
            check("cmp_ready", 64'(cfg_if.cfg_ready), 64'(m_ready));
            if (cfg_done_o === 1'b1) n_done++;
        end
    end

    // ---------------- stimulus helpers (called at a negedge, return at a negedge) ----
    task automatic send_word(input logic [31:0] w, input int gap, input bit free_hold);
        int waited;
        repeat (gap) @(negedge clk);
        cfg_if.cfg_data  = w;
        cfg_if.cfg_valid = 1'b1;
        waited = 0;
        while (cfg_if.cfg_ready !== 1'b1 && waited < 200) begin
            if (free_hold && waited > 3) hold_i = 1'b0;
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) begin
            n_checks++;
            n_errors++;
            $display("FAIL ready_timeout: ready stuck at %b, expected 1", cfg_if.cfg_ready);
        end
        if (waited > max_stall) max_stall = waited;
        @(posedge clk);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] hdr, input logic [159:0] pay, input int nw);
        send_word(hdr, 0, 1'b0);
        for (int k = 0; k < nw; k++) send_word(pay[32*k +: 32], 0, 1'b0);
    endtask

    task automatic pulse_flush();
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
    endtask

    logic [159:0] p1, p3, p4, px;
    int           done_before;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_data  = '0;
        p1 = {32'h00030ABC, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        p3 = {32'h0001F00D, 32'h76543210, 32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF};
        p4 = {32'h00020001, 32'hD0D0D0D0, 32'hC0C0C0C0, 32'hB0B0B0B0, 32'hA0A0A0A0};
        #1;
        check("rst_all", config_all_o, 64'h0);
        check("rst_ready", 64'(cfg_if.cfg_ready), 64'h0);
        check("rst_valid", 64'(cfg_valid_o), 64'h0);
        @(negedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // basic commit and done timing
        send_frame(32'hC5000500, p1, 5);
        check("t1_done_n0", 64'(cfg_done_o), 64'h0);
        check("t1_ready_commit", 64'(cfg_if.cfg_ready), 64'h0);
        @(negedge clk);
        check("t1_done_n1", 64'(cfg_done_o), 64'h1);
        check("t1_all", config_all_o, 64'h2222222211111111);
        check("t1_cb1", config_cb1_o, 64'h4444444433333333);
        check("t1_cb2", 64'(config_cb2_o), 64'h0ABC);
        check("t1_en", {62'h0, cb2_en_o, cb1_en_o}, 64'h3);
        check("t1_model_all", m_all, 64'h2222222211111111);
        @(negedge clk);
        check("t1_done_n2", 64'(cfg_done_o), 64'h0);

        // frame for another PE is consumed without stalls or effect
        max_stall = 0;
        done_before = n_done;
        send_frame(32'hC5070500, p3, 5);
        repeat (3) @(negedge clk);
        check("t2_stall", 64'(max_stall), 64'h0);
        check("t2_all", config_all_o, 64'h2222222211111111);
        check("t2_err", 64'(err_o), 64'h0);
        check("t2_no_done", 64'(n_done - done_before), 64'h0);

        // bad magic sets err; next good frame still commits
        send_word(32'hA5000500, 0, 1'b0);
        check("t3_err", 64'(err_o), 64'h1);
        check("t3_ready_idle", 64'(cfg_if.cfg_ready), 64'h1);
        send_frame(32'hC5000500, p3, 5);
        @(negedge clk);
        check("t3_all", config_all_o, 64'h01234567DEADBEEF);
        check("t3_cb1", config_cb1_o, 64'h7654321089ABCDEF);
        check("t3_cb2en", {46'h0, cb2_en_o, cb1_en_o, config_cb2_o}, 64'h1F00D);
        check("t3_err_sticky", 64'(err_o), 64'h1);

        // hold defers the commit
        send_frame(32'hC5000500, p4, 4);
        hold_i = 1'b1;
        send_word(p4[159:128], 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_hold_ready", 64'(cfg_if.cfg_ready), 64'h0);
            check("t4_hold_all", config_all_o, 64'h01234567DEADBEEF);
        end
        hold_i = 1'b0;
        @(negedge clk);
        check("t4_all", config_all_o, 64'hB0B0B0B0A0A0A0A0);
        check("t4_done", 64'(cfg_done_o), 64'h1);
        check("t4_en", {46'h0, cb2_en_o, cb1_en_o, config_cb2_o}, 64'h20001);

        // flush mid-frame keeps the active config and clears err
        send_frame(32'hC5000500, p3, 3);
        pulse_flush();
        check("t5_err", 64'(err_o), 64'h0);
        check("t5_all", config_all_o, 64'hB0B0B0B0A0A0A0A0);
        check("t5_ready", 64'(cfg_if.cfg_ready), 64'h1);
        send_frame(32'hC5000500, p1, 5);
        @(negedge clk);
        check("t5_recommit", config_all_o, 64'h2222222211111111);

        // wrong count skips that many words; broadcast loads; zero count
        send_frame(32'hC5000300, {32'h0, 32'h0, 32'hC5000500, 32'hC5000500, 32'hC5000500}, 3);
        check("t6_err", 64'(err_o), 64'h1);
        send_frame(32'hC5FF0500, p4, 5);
        @(negedge clk);
        check("t6_bcast", config_cb1_o, 64'hD0D0D0D0C0C0C0C0);
        send_word(32'hC5000000, 0, 1'b0);
        check("t6_zero_ready", 64'(cfg_if.cfg_ready), 64'h1);
        pulse_flush();

        // randomized traffic
        for (int f = 0; f < 40; f++) begin
            int unsigned kind;
            logic [7:0]  magic, id, cnt;
            int          nw;
            kind  = $urandom_range(0, 9);
            id    = (kind < 5) ? 8'h00 : (kind < 7) ? 8'hFF : 8'h07;
            magic = (kind == 8) ? 8'h5A : 8'hC5;
            cnt   = (kind == 9) ? 8'($urandom_range(0, 7)) : 8'd5;
            nw    = (magic != 8'hC5) ? 0 : int'(cnt);
            send_word({magic, id, cnt, 8'($urandom)}, $urandom_range(0, 2), 1'b1);
            for (int k = 0; k < nw; k++) begin
                hold_i = ($urandom_range(0, 3) == 0);
                send_word($urandom, $urandom_range(0, 2), 1'b1);
                if ($urandom_range(0, 15) == 0) pulse_flush();
            end
            if ($urandom_range(0, 7) == 0) pulse_flush();
        end
        hold_i = 1'b0;
        repeat (4) @(negedge clk);

        // asynchronous reset in the middle of a load
        send_frame(32'hC5000500, p3, 2);
        done_before = n_done;
        #2 rst_n = 1'b0;
        #1;
        check("t8_all", config_all_o, 64'h0);
        check("t8_cb1", config_cb1_o, 64'h0);
        check("t8_flags", {58'h0, cfg_if.cfg_ready, cfg_valid_o, cfg_done_o, err_o,
                          cb2_en_o, cb1_en_o}, 64'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t8_no_done", 64'(n_done - done_before), 64'h0);
        send_frame(32'hC5000500, p1, 5);
        @(negedge clk);
        check("t8_recommit", config_all_o, 64'h2222222211111111);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
